// File: rtl/clk_div_ratio_ctrl_if.sv
// Config and output bundle for clk_div_ratio_ctrl.
// The master side issues ratio requests and the run level; the slave side is the divider.
interface clk_div_ratio_ctrl_if #(
  parameter int W = 8
);
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clk_out;
  logic         tick;
  logic         busy;
  logic [W-1:0] cur_div;

  modport master (
    output en, cfg_valid, cfg_div,
    input  cfg_ready, cfg_err, clk_out, tick, busy, cur_div
  );

  modport slave (
    input  en, cfg_valid, cfg_div,
    output cfg_ready, cfg_err, clk_out, tick, busy, cur_div
  );
endinterface

// File: rtl/clk_div_ratio_ctrl.sv
// Programmable integer clock divider with a glitch-free ratio/enable controller.
// Ratio changes and stops take effect only on output-period boundaries.
module clk_div_ratio_ctrl #(
  parameter int W       = 8,
  parameter int DEF_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  clk_div_ratio_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } state_t;

  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] TWO   = W'(2);
  localparam logic [W-1:0] DEF_N = W'(DEF_DIV);

  state_t       state_q;
  logic [W-1:0] cnt_q;
  logic [W-1:0] cur_div_q;
  logic [W-1:0] shadow_q;
  logic         clk_out_q;
  logic         tick_q;
  logic         err_q;

  logic         cfg_ready;
  logic         xfer;
  logic         legal;
  logic         last;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] half_div;

  // Handshake qualification and period-boundary detection, all in W bits.
  always_comb begin
    cfg_ready = (state_q != PEND);
    xfer      = bus.cfg_valid && cfg_ready;
    legal     = (bus.cfg_div >= TWO);
    last      = (cnt_q == (cur_div_q - ONE));
    cnt_inc   = cnt_q + ONE;
    half_div  = cur_div_q >> 1;
  end

  // Controller FSM with counter and registered outputs.
  // Every entry into cnt=0 of a running period drives clk_out=1 directly:
  // 0 < N>>1 always holds because N>=2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_div_q <= DEF_N;
      shadow_q  <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q  <= xfer && !legal;
      tick_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (xfer && legal) cur_div_q <= bus.cfg_div;
          if (bus.en) begin
            state_q   <= RUN;
            clk_out_q <= 1'b1;
            tick_q    <= 1'b1;
          end else begin
            clk_out_q <= 1'b0;
          end
        end
        RUN, PEND: begin
          if (last) begin
            if (state_q == PEND)    cur_div_q <= shadow_q;
            else if (xfer && legal) cur_div_q <= bus.cfg_div;
            cnt_q <= '0;
            if (bus.en) begin
              state_q   <= RUN;
              clk_out_q <= 1'b1;
              tick_q    <= 1'b1;
            end else begin
              state_q   <= IDLE;
              clk_out_q <= 1'b0;
            end
          end else begin
            cnt_q     <= cnt_inc;
            clk_out_q <= (cnt_inc < half_div);
            if (state_q == RUN && xfer && legal) begin
              state_q  <= PEND;
              shadow_q <= bus.cfg_div;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          clk_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready = cfg_ready;
  assign bus.cfg_err   = err_q;
  assign bus.clk_out   = clk_out_q;
  assign bus.tick      = tick_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.cur_div   = cur_div_q;

endmodule

// File: tb/tb_clk_div_ratio_ctrl.sv
// Scoreboard bench for clk_div_ratio_ctrl: a period-position model predicts every
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_clk_div_ratio_ctrl;

  logic clk;
  logic rst;

  clk_div_ratio_ctrl_if #(.W(8)) bus ();

  clk_div_ratio_ctrl #(.W(8), .DEF_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       clk_out;
    logic       tick;
    logic       busy;
    logic       ready;
    logic       err;
    logic [7:0] cur_div;
  } obs_t;

  obs_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model: position inside the output period plus the ratio in effect.
  bit m_run;
  int m_pos;
  int m_n;
  int m_pend;
  bit m_err;

  task automatic m_reset();
    m_run  = 0;
    m_pos  = 0;
    m_n    = 4;
    m_pend = 0;
    m_err  = 0;
  endtask

  function automatic obs_t m_out();
    obs_t o;
    o.clk_out = m_run && (m_pos < m_n / 2);
    o.tick    = m_run && (m_pos == 0);
    o.busy    = m_run;
    o.ready   = (m_pend == 0);
    o.err     = m_err;
    o.cur_div = 8'(m_n);
    return o;
  endfunction

  function automatic void m_step(input bit en, input bit v, input int d);
    bit acc;
    bit ok;
    acc   = v && (m_pend == 0);
    ok    = (d >= 2);
    m_err = acc && !ok;
    if (!m_run) begin
      if (acc && ok) m_n = d;
      if (en) begin
        m_run = 1;
        m_pos = 0;
      end
    end else if (m_pos == m_n - 1) begin
      if (m_pend != 0) begin
        m_n    = m_pend;
        m_pend = 0;
      end else if (acc && ok) begin
        m_n = d;
      end
      m_pos = 0;
      if (!en) m_run = 0;
    end else begin
      m_pos = m_pos + 1;
      if (acc && ok) m_pend = d;
    end
  endfunction

  // One clock of stimulus: record the expectation for the state now visible,
  // then drive inputs for the coming edge and advance the model with them.
  task automatic cycle(input bit en, input bit v, input int d);
    @(posedge clk);
    #1;
    exp_q.push_back(m_out());
    bus.en        = en;
    bus.cfg_valid = v;
    bus.cfg_div   = 8'(d);
    m_step(en, v, d);
  endtask

  // Run with en held high until the model reaches period position p.
  task automatic run_to_pos(input int p);
    int guard;
    guard = 0;
    while (m_pos != p && guard < 600) begin
      cycle(1, 0, 0);
      guard++;
    end
    if (m_pos != p) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to_pos: position %0d, required %0d", m_pos, p);
    end
  endtask

  // Monitor: pop and compare one expectation per cycle.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a.clk_out = bus.clk_out;
        a.tick    = bus.tick;
        a.busy    = bus.busy;
        a.ready   = bus.cfg_ready;
        a.err     = bus.cfg_err;
        a.cur_div = bus.cur_div;
        vectors++;
        if (a !== e) begin
          miscompares++;
          $display("FAIL cycle t=%0t got clk_out=%b tick=%b busy=%b ready=%b err=%b cur_div=%0d required clk_out=%b tick=%b busy=%b ready=%b err=%b cur_div=%0d",
                   $time, a.clk_out, a.tick, a.busy, a.ready, a.err, a.cur_div,
                   e.clk_out, e.tick, e.busy, e.ready, e.err, e.cur_div);
        end
      end
    end
  end

  task automatic do_reset();
    rst           = 1'b1;
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit en_r;
    int sel;
    int d;

    do_reset();

    // Default ratio: 1100 pattern, tick every 4.
    repeat (12) cycle(1, 0, 0);

    // Ratio change mid-period goes through PEND.
    run_to_pos(1);
    cycle(1, 1, 6);
    repeat (16) cycle(1, 0, 0);

    // Ratio change in the boundary cycle skips PEND.
    run_to_pos(m_n - 1);
    cycle(1, 1, 5);
    repeat (12) cycle(1, 0, 0);

    // Illegal ratios are discarded with an error pulse.
    cycle(1, 1, 1);
    cycle(1, 0, 0);
    cycle(1, 1, 0);
    repeat (8) cycle(1, 0, 0);

    // Graceful stop at N=6, then a stop cancelled before the boundary.
    run_to_pos(m_n - 1);
    cycle(1, 1, 6);
    run_to_pos(1);
    repeat (10) cycle(0, 0, 0);
    cycle(1, 0, 0);
    run_to_pos(1);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    repeat (12) cycle(1, 0, 0);

    // Randomized traffic.
    en_r = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en_r = !en_r;
      sel = $urandom_range(0, 15);
      if (sel == 0)      d = 0;
      else if (sel == 1) d = 1;
      else if (sel == 2) d = ($urandom_range(0, 3) == 0) ? 255 : 2;
      else if (sel == 3) d = 3;
      else               d = $urandom_range(2, 9);
      cycle(en_r, ($urandom_range(0, 7) == 0), d);
    end
    repeat (300) cycle(0, 0, 0);

    // N=255: start in IDLE, then reset in the middle of the high phase.
    cycle(1, 1, 255);
    repeat (60) cycle(1, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    m_reset();
    vectors++;
    if (bus.clk_out !== 1'b0 || bus.cur_div !== 8'd4 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset: got clk_out=%b cur_div=%0d busy=%b ready=%b, required clk_out=0 cur_div=4 busy=0 ready=1",
               bus.clk_out, bus.cur_div, bus.busy, bus.cfg_ready);
    end
    bus.en        = 1'b0;
    bus.cfg_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full N=255 periods: 127 high, 128 low, tick every 255.
    cycle(1, 1, 255);
    repeat (600) cycle(1, 0, 0);
    repeat (300) cycle(0, 0, 0);

    @(negedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
